// File: rtl/rv64_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv64_pkg
// Description : Shared integer register-file constants for the writeback path.
// Revision    : 1.0 - initial release
// ============================================================================
package rv64_pkg;

    // Number of architectural integer registers (x0..x31)
    localparam int NUM_GPR = 32;

    // Hard-wired zero register; writes to it are accepted but discarded
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : rv64_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. The search starts at the
//               pointer position and wraps modulo N; the first asserted
//               request wins and is reported as a one-hot grant plus index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW-1:0] cand_w;

    // Scan requesters starting at the pointer; the first valid one wins
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand_w  = '0;
        for (int k = 0; k < N; k++) begin
            cand_w = IW'((int'(ptr_i) + k) % N);
            if (!valid_o && req_i[cand_w]) begin
                grant_o[cand_w] = 1'b1;
                idx_o           = cand_w;
                valid_o         = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin arbitration of NUM_REQ writeback sources onto the
//               single register-file write port, with a registered output
//               stage and a pending-write scoreboard for RAW hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import rv64_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REQ    = 3
) (
    input  logic                          in_Clk,
    input  logic                          in_Rst,
    input  logic                          in_hold,
    input  logic [NUM_REQ-1:0]            in_req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] in_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_req_data,
    output logic [NUM_REQ-1:0]            out_req_ready,
    output logic                          out_rf_write_En,
    output logic [ADDR_WIDTH-1:0]         out_rf_writeAddr,
    output logic [DATA_WIDTH-1:0]         out_rf_data,
    output logic [$clog2(NUM_REQ)-1:0]    out_grant_id,
    input  logic                          in_issue_valid,
    input  logic [ADDR_WIDTH-1:0]         in_issue_addr,
    input  logic [ADDR_WIDTH-1:0]         in_chk_addr_A,
    input  logic [ADDR_WIDTH-1:0]         in_chk_addr_B,
    output logic                          out_hazard_A,
    output logic                          out_hazard_B,
    output logic [NUM_GPR-1:0]            out_busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    // Arbitration signals
    logic [NUM_REQ-1:0]    req_masked;
    logic [NUM_REQ-1:0]    arb_grant;
    logic [IDW-1:0]        arb_idx;
    logic                  arb_valid;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // State
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [IDW-1:0]        gid_q;
    logic [NUM_GPR-1:0]    busy_q, busy_d;

    // Hold suppresses every request so no grant (and no pointer move) happens
    assign req_masked = in_hold ? '0 : in_req_valid;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_rr_arbiter (
        .req_i   (req_masked),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign out_req_ready = arb_grant;

    // Route the winning requester's address and data slice
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_addr = in_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = in_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Pointer advances to the slot after the winner; unchanged without a grant
    always_comb begin
        ptr_d = ptr_q;
        if (arb_valid) begin
            ptr_d = (arb_idx == IDW'(NUM_REQ - 1)) ? '0 : arb_idx + IDW'(1);
        end
    end

    // Scoreboard update: clear on strobe, then set on issue so a new writer wins
    always_comb begin
        busy_d = busy_q;
        if (we_q) begin
            busy_d[waddr_q] = 1'b0;
        end
        if (in_issue_valid && (in_issue_addr != ZERO_ADDR)) begin
            busy_d[in_issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Round-robin pointer register
    always_ff @(posedge in_Clk or posedge in_Rst) begin
        if (in_Rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Output stage: strobe only non-x0 grants; address/data/id hold when idle
    always_ff @(posedge in_Clk or posedge in_Rst) begin
        if (in_Rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            gid_q   <= '0;
        end else begin
            we_q <= arb_valid && (sel_addr != ZERO_ADDR);
            if (arb_valid) begin
                waddr_q <= sel_addr;
                wdata_q <= sel_data;
                gid_q   <= arb_idx;
            end
        end
    end

    // Pending-write scoreboard register
    always_ff @(posedge in_Clk or posedge in_Rst) begin
        if (in_Rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign out_rf_write_En  = we_q;
    assign out_rf_writeAddr = waddr_q;
    assign out_rf_data      = wdata_q;
    assign out_grant_id     = gid_q;
    assign out_busy         = busy_q;

    // Hazard lookup; busy[0] is never set so x0 never reports a hazard
    assign out_hazard_A = busy_q[in_chk_addr_A];
    assign out_hazard_B = busy_q[in_chk_addr_B];

endmodule : regfile_wb_arbiter
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NR = 3;

    logic          clk;
    logic          rst;
    logic          hold;
    logic [NR-1:0] vld;
    logic [AW-1:0] a [NR];
    logic [DW-1:0] d [NR];
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0] rdy;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [1:0]    gid;
    logic          iss_v;
    logic [AW-1:0] iss_a;
    logic [AW-1:0] chk_a;
    logic [AW-1:0] chk_b;
    logic          haz_a;
    logic          haz_b;
    logic [31:0]   busy;

    int checks = 0;
    int errors = 0;

    assign req_addr = {a[2], a[1], a[0]};
    assign req_data = {d[2], d[1], d[0]};

    regfile_wb_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REQ    (NR)
    ) dut (
        .in_Clk           (clk),
        .in_Rst           (rst),
        .in_hold          (hold),
        .in_req_valid     (vld),
        .in_req_addr      (req_addr),
        .in_req_data      (req_data),
        .out_req_ready    (rdy),
        .out_rf_write_En  (we),
        .out_rf_writeAddr (waddr),
        .out_rf_data      (wdata),
        .out_grant_id     (gid),
        .in_issue_valid   (iss_v),
        .in_issue_addr    (iss_a),
        .in_chk_addr_A    (chk_a),
        .in_chk_addr_B    (chk_b),
        .out_hazard_A     (haz_a),
        .out_hazard_B     (haz_b),
        .out_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        hold  = 1'b0;
        vld   = '0;
        iss_v = 1'b0;
        iss_a = '0;
        chk_a = '0;
        chk_b = '0;
        for (int i = 0; i < NR; i++) begin
            a[i] = '0;
            d[i] = '0;
        end
        tick();
        tick();
        check("rst_we",    {63'd0, we}, 64'd0);
        check("rst_addr",  {59'd0, waddr}, 64'd0);
        check("rst_data",  wdata, 64'd0);
        check("rst_gid",   {62'd0, gid}, 64'd0);
        check("rst_busy",  {32'd0, busy}, 64'd0);
        rst = 1'b0;
        tick();

        // Contention: all valid, round-robin 0,1,2,0
        for (int i = 0; i < NR; i++) begin
            a[i] = AW'(i + 1);
            d[i] = 64'h100 + 64'(i);
        end
        vld = 3'b111;
        #1;
        check("cont_rdy0", {61'd0, rdy}, 64'b001);
        tick();
        check("cont_we1",   {63'd0, we}, 64'd1);
        check("cont_addr1", {59'd0, waddr}, 64'd1);
        check("cont_data1", wdata, 64'h100);
        check("cont_rdy1",  {61'd0, rdy}, 64'b010);
        tick();
        check("cont_addr2", {59'd0, waddr}, 64'd2);
        check("cont_gid2",  {62'd0, gid}, 64'd1);
        check("cont_rdy2",  {61'd0, rdy}, 64'b100);
        tick();
        check("cont_addr3", {59'd0, waddr}, 64'd3);
        check("cont_data3", wdata, 64'h102);
        check("cont_rdy3",  {61'd0, rdy}, 64'b001);
        tick();
        check("cont_addr4", {59'd0, waddr}, 64'd1);
        check("cont_gid4",  {62'd0, gid}, 64'd0);

        // Hold: no grant, no strobe, pointer stays at 1
        hold = 1'b1;
        #1;
        check("hold_rdy", {61'd0, rdy}, 64'd0);
        tick();
        check("hold_we",   {63'd0, we}, 64'd0);
        check("hold_addr", {59'd0, waddr}, 64'd1);
        hold = 1'b0;
        #1;
        check("resume_rdy", {61'd0, rdy}, 64'b010);
        tick();
        check("resume_we",   {63'd0, we}, 64'd1);
        check("resume_addr", {59'd0, waddr}, 64'd2);
        vld = '0;
        tick();
        check("idle_we", {63'd0, we}, 64'd0);

        // Single request on requester 1 (pointer is now 2)
        a[1] = 5'd5;
        d[1] = 64'hDEAD_BEEF;
        vld  = 3'b010;
        #1;
        check("single_rdy", {61'd0, rdy}, 64'b010);
        tick();
        vld = '0;
        check("single_we",   {63'd0, we}, 64'd1);
        check("single_addr", {59'd0, waddr}, 64'd5);
        check("single_data", wdata, 64'hDEAD_BEEF);
        check("single_gid",  {62'd0, gid}, 64'd1);

        // x0 write: accepted but never strobed (pointer is 2)
        a[0] = 5'd0;
        d[0] = 64'h55;
        vld  = 3'b001;
        #1;
        check("x0_rdy", {61'd0, rdy}, 64'b001);
        tick();
        vld = '0;
        check("x0_we",  {63'd0, we}, 64'd0);
        check("x0_gid", {62'd0, gid}, 64'd0);

        // Scoreboard: issue rd=7 (pointer is now 1)
        iss_v = 1'b1;
        iss_a = 5'd7;
        tick();
        iss_v = 1'b0;
        chk_a = 5'd7;
        chk_b = 5'd0;
        #1;
        check("sb_busy7", {32'd0, busy}, 64'h80);
        check("sb_hazA",  {63'd0, haz_a}, 64'd1);
        check("sb_hazB0", {63'd0, haz_b}, 64'd0);

        // Writeback to 7 via requester 2, with same-cycle reissue of 7
        a[2] = 5'd7;
        d[2] = 64'h77;
        vld  = 3'b100;
        #1;
        check("sb_wb_rdy", {61'd0, rdy}, 64'b100);
        tick();
        vld = '0;
        check("sb_wb_we", {63'd0, we}, 64'd1);
        iss_v = 1'b1;
        iss_a = 5'd7;
        tick();
        iss_v = 1'b0;
        check("sb_setwins", {32'd0, busy}, 64'h80);

        // Plain writeback to 7 clears it the cycle after the strobe
        a[0] = 5'd7;
        vld  = 3'b001;
        tick();
        vld = '0;
        check("sb_wb2_we", {63'd0, we}, 64'd1);
        check("sb_still",  {63'd0, haz_a}, 64'd1);
        tick();
        check("sb_clear", {32'd0, busy}, 64'd0);
        check("sb_hazA0", {63'd0, haz_a}, 64'd0);

        // Issue rd=0 never marks anything; issue rd=3 then check via port B
        iss_v = 1'b1;
        iss_a = 5'd0;
        tick();
        check("sb_x0", {32'd0, busy}, 64'd0);
        iss_a = 5'd3;
        tick();
        iss_v = 1'b0;
        chk_b = 5'd3;
        #1;
        check("sb_hazB3", {63'd0, haz_b}, 64'd1);

        // Async reset mid-write clears strobe and scoreboard without a clock edge
        a[1] = 5'd9;
        d[1] = 64'h99;
        vld  = 3'b010;
        tick();
        vld = '0;
        check("pre_rst_we", {63'd0, we}, 64'd1);
        rst = 1'b1;
        #1;
        check("arst_we",   {63'd0, we}, 64'd0);
        check("arst_busy", {32'd0, busy}, 64'd0);
        check("arst_addr", {59'd0, waddr}, 64'd0);
        tick();
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
`default_nettype wire
